// File: rtl/core_switch_ctrl_pkg.sv
// Shared constants for the dual-core switchover controller: FSM encodings and debounce default.
package core_switch_ctrl_pkg;

   localparam int unsigned DebCyclesDefault = 1000;

   localparam logic [1:0] StInit = 2'd0;
   localparam logic [1:0] StActA = 2'd1;
   localparam logic [1:0] StActB = 2'd2;
   localparam logic [1:0] StFail = 2'd3;

endpackage

// File: rtl/heartbeat_debounce.sv
// Debounces one raw health input: the flag follows raw only after DEB_CYCLES
// consecutive clocks of disagreement.
module heartbeat_debounce
   import core_switch_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic good
);

   logic [31:0] cnt_q;
   logic        good_q;

   // Counter tops out at DEB_CYCLES-1 where the flag flips and the count restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         good_q <= 1'b0;
      end else if (raw != good_q) begin
         if (cnt_q == DEB_CYCLES - 32'd1) begin
            good_q <= raw;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign good = good_q;

endmodule

// File: rtl/core_switch_ctrl.sv
// Active/standby core selector: debounced health flags drive a non-revertive
// changeover FSM with registered select, fail and switch pulse.
module core_switch_ctrl
   import core_switch_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ok_a,
   input  logic       ok_b,
   input  logic       force_sw,
   output logic       a_good,
   output logic       b_good,
   output logic       sel_b,
   output logic       fail,
   output logic       switch_pulse,
   output logic [1:0] state
);

   logic [1:0] state_q, state_d;
   logic       sel_q, sel_d;
   logic       fail_q, fail_d;
   logic       pulse_q, pulse_d;

   heartbeat_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb_a (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ok_a),
      .good (a_good)
   );

   heartbeat_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb_b (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ok_b),
      .good (b_good)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit, StFail: begin
            if (a_good) begin
               state_d = StActA;
            end else if (b_good) begin
               state_d = StActB;
            end
         end
         StActA: begin
            // Active-core failure takes precedence over any coincident force request.
            if (!a_good) begin
               state_d = b_good ? StActB : StFail;
            end else if (b_good && force_sw) begin
               state_d = StActB;
            end
         end
         StActB: begin
            if (!b_good) begin
               state_d = a_good ? StActA : StFail;
            end else if (a_good && force_sw) begin
               state_d = StActA;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      sel_d = sel_q;
      if (state_d == StActA) begin
         sel_d = 1'b0;
      end else if (state_d == StActB) begin
         sel_d = 1'b1;
      end
      fail_d  = (state_d == StInit) || (state_d == StFail);
      pulse_d = (sel_d != sel_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
         sel_q   <= 1'b0;
         fail_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         fail_q  <= fail_d;
         pulse_q <= pulse_d;
      end
   end

   assign state        = state_q;
   assign sel_b        = sel_q;
   assign fail         = fail_q;
   assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_core_switch_ctrl.sv
// Directed bench for core_switch_ctrl with an 8-clock debounce window.
module tb_core_switch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       ok_a;
   logic       ok_b;
   logic       force_sw;
   logic       a_good;
   logic       b_good;
   logic       sel_b;
   logic       fail;
   logic       switch_pulse;
   logic [1:0] state;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   core_switch_ctrl #(
      .DEB_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ok_a        (ok_a),
      .ok_b        (ok_b),
      .force_sw    (force_sw),
      .a_good      (a_good),
      .b_good      (b_good),
      .sel_b       (sel_b),
      .fail        (fail),
      .switch_pulse(switch_pulse),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_outs(input string tag, input logic [1:0] st, input logic sb,
                             input logic fl, input logic sp);
      check({tag, ".state"}, {30'd0, state}, {30'd0, st});
      check({tag, ".sel_b"}, {31'd0, sel_b}, {31'd0, sb});
      check({tag, ".fail"}, {31'd0, fail}, {31'd0, fl});
      check({tag, ".pulse"}, {31'd0, switch_pulse}, {31'd0, sp});
   endtask

   initial begin
      rst_n    = 1'b0;
      ok_a     = 1'b0;
      ok_b     = 1'b0;
      force_sw = 1'b0;
      tick(2);
      check_outs("reset", 2'd0, 1'b0, 1'b1, 1'b0);
      check("reset.a_good", {31'd0, a_good}, 32'd0);
      check("reset.b_good", {31'd0, b_good}, 32'd0);

      // Both healthy from release: flags rise on the 8th edge, ACT_A on the 9th.
      rst_n = 1'b1;
      ok_a  = 1'b1;
      ok_b  = 1'b1;
      tick(7);
      check("qual7.a_good", {31'd0, a_good}, 32'd0);
      tick(1);
      check("qual8.a_good", {31'd0, a_good}, 32'd1);
      check("qual8.b_good", {31'd0, b_good}, 32'd1);
      check("qual8.state", {30'd0, state}, 32'd0);
      tick(1);
      check_outs("init_to_a", 2'd1, 1'b0, 1'b0, 1'b0);

      // 7-clock glitch on A is filtered.
      ok_a = 1'b0;
      tick(7);
      ok_a = 1'b1;
      tick(1);
      check("glitch.a_good", {31'd0, a_good}, 32'd1);
      tick(3);
      check_outs("glitch", 2'd1, 1'b0, 1'b0, 1'b0);

      // 8-clock loss of A switches to B with a single pulse.
      ok_a = 1'b0;
      tick(8);
      check("loss_a.a_good", {31'd0, a_good}, 32'd0);
      check("loss_a.state", {30'd0, state}, 32'd1);
      tick(1);
      check_outs("a_to_b", 2'd2, 1'b1, 1'b0, 1'b1);
      tick(1);
      check_outs("a_to_b+1", 2'd2, 1'b1, 1'b0, 1'b0);

      // Recovery of A does not switch back.
      ok_a = 1'b1;
      tick(100);
      check("nonrev.a_good", {31'd0, a_good}, 32'd1);
      check_outs("nonrev", 2'd2, 1'b1, 1'b0, 1'b0);

      // Manual changeover back to A.
      force_sw = 1'b1;
      tick(1);
      force_sw = 1'b0;
      check_outs("force", 2'd1, 1'b0, 1'b0, 1'b1);
      tick(1);
      check_outs("force+1", 2'd1, 1'b0, 1'b0, 1'b0);

      // Both lost: FAIL with sel_b held at 0.
      ok_a = 1'b0;
      ok_b = 1'b0;
      tick(9);
      check_outs("both_lost", 2'd3, 1'b0, 1'b1, 1'b0);

      // Only B returns: FAIL -> ACT_B with a pulse.
      ok_b = 1'b1;
      tick(8);
      check("fail_b.b_good", {31'd0, b_good}, 32'd1);
      check("fail_b.state", {30'd0, state}, 32'd3);
      tick(1);
      check_outs("fail_to_b", 2'd2, 1'b1, 1'b0, 1'b1);

      // Force ignored while standby A is not good.
      force_sw = 1'b1;
      tick(1);
      force_sw = 1'b0;
      check_outs("force_ign", 2'd2, 1'b1, 1'b0, 1'b0);

      // Reset mid-debounce (B counter at 5) acts without a clock edge.
      ok_b = 1'b0;
      tick(5);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 2'd0, 1'b0, 1'b1, 1'b0);
      check("async_rst.b_good", {31'd0, b_good}, 32'd0);
      tick(1);

      // Full re-qualification after release.
      ok_b  = 1'b1;
      rst_n = 1'b1;
      tick(7);
      check("requal7.b_good", {31'd0, b_good}, 32'd0);
      tick(1);
      check("requal8.b_good", {31'd0, b_good}, 32'd1);
      tick(1);
      check_outs("requal_b", 2'd2, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
